onehot_encoder_8to3: RTL and testbench

- Inverse of the team's 3-to-8 one-hot decoder: takes an 8-bit one-hot word and returns the 3-bit code, so decoded select lines can be converted back to binary.
- Registered, with a valid/ready handshake on input and output.
- Classifies every accepted word as clean one-hot, all-zero, or multi-hot, and counts errors.
- Sits between a decoded select bus and the binary-indexed logic that consumes it.

---
 rtl/enc_pkg.sv | 25 ++
 rtl/onehot_prio_enc.sv | 32 +++
 rtl/onehot_encoder_8to3.sv | 92 +++++++++
 tb/tb_onehot_encoder_8to3.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, state type and word classification for the one-hot encoder.
package enc_pkg;

  localparam int ONEHOT_W = 8;
  localparam int CODE_W   = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ONEHOT = 2'd0,
    ZERO   = 2'd1,
    MULTI  = 2'd2
  } word_cls_e;

  // w & (w-1) clears the lowest set bit; nothing left means at most one bit was set.
  function automatic word_cls_e classify(input logic [ONEHOT_W-1:0] w);
    if (w == '0) return ZERO;
    if ((w & (w - 1'b1)) == '0) return ONEHOT;
    return MULTI;
  endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational one-hot to binary encoder with selectable multi-hot priority.
module onehot_prio_enc
  import enc_pkg::*;
#(
  parameter bit PRIO_MSB = 1'b1
) (
  input  logic [ONEHOT_W-1:0] word,
  output logic [CODE_W-1:0]   code,
  output logic                zero,
  output logic                multi
);

  word_cls_e cls;

  // The scan direction decides which set bit is written last and therefore wins.
  always_comb begin
    cls   = classify(word);
    zero  = (cls == ZERO);
    multi = (cls == MULTI);
    code  = '0;
    if (PRIO_MSB) begin
      for (int i = 0; i < ONEHOT_W; i++) begin
        if (word[i]) code = CODE_W'(i);
      end
    end else begin
      for (int i = ONEHOT_W - 1; i >= 0; i--) begin
        if (word[i]) code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_encoder_8to3.sv
// Registered one-hot to binary encoder with valid/ready handshake and a
// saturating count of zero / multi-hot words.
module onehot_encoder_8to3
  import enc_pkg::*;
#(
  parameter int PRIO_MSB = 1,
  parameter int ERR_W    = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [ONEHOT_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CODE_W-1:0]   out_code,
  output logic                out_zero,
  output logic                out_multi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ERR_W-1:0]    err_cnt,
  input  logic                err_clr
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [CODE_W-1:0] code_p0;
  logic              zero_p0;
  logic              multi_p0;
  logic              accept;
  logic              err_hit;
  logic [ERR_W-1:0]  err_base;

  logic [CODE_W-1:0] code_p1;
  logic              zero_p1;
  logic              multi_p1;
  logic [ERR_W-1:0]  err_p1;
  state_e            state_p1;
  state_e            state_nxt;
  logic              vld_p1;

  onehot_prio_enc #(
    .PRIO_MSB (PRIO_MSB != 0)
  ) u_enc (
    .word  (in_data),
    .code  (code_p0),
    .zero  (zero_p0),
    .multi (multi_p0)
  );

  assign vld_p1   = (state_p1 == FULL);
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign err_hit  = accept && (zero_p0 || multi_p0);
  // Clear takes effect before the increment so a clear with an error lands on 1.
  assign err_base = err_clr ? '0 : err_p1;

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (!accept && out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- stage p0 -> p1: output register, FSM and error counter ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_p1 <= EMPTY;
      code_p1  <= '0;
      zero_p1  <= 1'b0;
      multi_p1 <= 1'b0;
      err_p1   <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (accept) begin
        code_p1  <= code_p0;
        zero_p1  <= zero_p0;
        multi_p1 <= multi_p0;
      end
      err_p1 <= err_hit ? sat_inc(err_base) : err_base;
    end
  end

  assign out_code  = code_p1;
  assign out_zero  = zero_p1;
  assign out_multi = multi_p1;
  assign out_valid = vld_p1;
  assign err_cnt   = err_p1;

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Scoreboard bench: two encoders (MSB priority / 8-bit counter and LSB priority / 2-bit counter) on shared stimulus.
module tb_onehot_encoder_8to3;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       err_clr;

  logic       in_ready_a, out_zero_a, out_multi_a, out_valid_a;
  logic [2:0] out_code_a;
  logic [7:0] err_cnt_a;
  logic       in_ready_b, out_zero_b, out_multi_b, out_valid_b;
  logic [2:0] out_code_b;
  logic [1:0] err_cnt_b;

  always #5 sys_clk = ~sys_clk;

  onehot_encoder_8to3 #(.PRIO_MSB(1), .ERR_W(8)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_code(out_code_a), .out_zero(out_zero_a),
    .out_multi(out_multi_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .err_cnt(err_cnt_a), .err_clr(err_clr)
  );

  onehot_encoder_8to3 #(.PRIO_MSB(0), .ERR_W(2)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_code(out_code_b), .out_zero(out_zero_b),
    .out_multi(out_multi_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .err_cnt(err_cnt_b), .err_clr(err_clr)
  );

  typedef struct {
    logic [2:0] cm;
    logic [2:0] cl;
    logic       z;
    logic       m;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic m_full = 1'b0;
  int   m_err_a = 0;
  int   m_err_b = 0;

  function automatic exp_t model(input logic [7:0] w);
    exp_t e;
    int   n;
    bit   found;
    n    = $countones(w);
    e.z  = (n == 0);
    e.m  = (n > 1);
    e.cm = 3'd0;
    e.cl = 3'd0;
    found = 0;
    for (int i = 7; i >= 0; i--) if (!found && w[i]) begin e.cm = 3'(i); found = 1; end
    found = 0;
    for (int i = 0; i < 8; i++) if (!found && w[i]) begin e.cl = 3'(i); found = 1; end
    return e;
  endfunction

  // Drives one clock of stimulus and updates the reference model; no comparisons here.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                     input logic ordy, input logic clr);
    logic acc;
    exp_t e;
    sys_rst = r; in_valid = v; in_data = d; out_ready = ordy; err_clr = clr;
    acc = !r && v && (!m_full || ordy);
    e = model(d);
    @(posedge sys_clk);
    #1;
    if (r) begin
      m_full = 1'b0; m_err_a = 0; m_err_b = 0; sb.delete();
    end else begin
      if (clr) begin m_err_a = 0; m_err_b = 0; end
      if (acc && (e.z || e.m)) begin
        if (m_err_a < 255) m_err_a++;
        if (m_err_b < 3) m_err_b++;
      end
      m_full = acc || (m_full && !ordy);
      if (acc) sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 1, 8'hff, 1, 1);
    cyc(0, 0, 8'h00, 0, 0);
    checks++;
    if ({out_valid_a, out_code_a, out_zero_a, out_multi_a, err_cnt_a, in_ready_a} !== {1'b0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_a: got v=%b c=%0d z=%b m=%b e=%0d r=%b want 0 0 0 0 0 1",
               out_valid_a, out_code_a, out_zero_a, out_multi_a, err_cnt_a, in_ready_a);
    end
    checks++;
    if ({out_valid_b, out_code_b, out_zero_b, out_multi_b, err_cnt_b, in_ready_b} !== {1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_b: got v=%b c=%0d z=%b m=%b e=%0d r=%b want 0 0 0 0 0 1",
               out_valid_b, out_code_b, out_zero_b, out_multi_b, err_cnt_b, in_ready_b);
    end
  endtask

  task automatic test_single();
    exp_t e;
    cyc(0, 1, 8'h10, 1, 0);
    e = sb.pop_front();
    checks++;
    if ({out_valid_a, out_code_a, out_zero_a, out_multi_a} !== {1'b1, e.cm, e.z, e.m} || out_code_a !== 3'd4) begin
      errors++;
      $display("FAIL single_a: got v=%b c=%0d z=%b m=%b want 1 4 0 0", out_valid_a, out_code_a, out_zero_a, out_multi_a);
    end
    checks++;
    if (err_cnt_a !== 8'(m_err_a) || err_cnt_b !== 2'(m_err_b)) begin
      errors++;
      $display("FAIL single_err: got a=%0d b=%0d want %0d %0d", err_cnt_a, err_cnt_b, m_err_a, m_err_b);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 8'(1 << k), 1, 0);
      e = sb.pop_front();
      checks++;
      if ({out_valid_a, out_code_a, in_ready_a, out_valid_b, out_code_b, in_ready_b} !== {1'b1, e.cm, 1'b1, 1'b1, e.cl, 1'b1}) begin
        errors++;
        $display("FAIL sweep[%0d]: got va=%b ca=%0d ra=%b vb=%b cb=%0d rb=%b want code %0d, valid/ready 1",
                 k, out_valid_a, out_code_a, in_ready_a, out_valid_b, out_code_b, in_ready_b, k);
      end
    end
    cyc(0, 0, 8'h00, 1, 0);
    checks++;
    if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL drain: got va=%b vb=%b want 0", out_valid_a, out_valid_b);
    end
  endtask

  task automatic test_errors();
    exp_t e;
    logic [7:0] words [2];
    words[0] = 8'h00;
    words[1] = 8'h24;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, words[k], 1, 0);
      e = sb.pop_front();
      checks++;
      if ({out_valid_a, out_code_a, out_zero_a, out_multi_a, err_cnt_a} !== {1'b1, e.cm, e.z, e.m, 8'(m_err_a)}) begin
        errors++;
        $display("FAIL errword_a[%02h]: got c=%0d z=%b m=%b e=%0d want c=%0d z=%b m=%b e=%0d",
                 words[k], out_code_a, out_zero_a, out_multi_a, err_cnt_a, e.cm, e.z, e.m, m_err_a);
      end
      checks++;
      if ({out_valid_b, out_code_b, out_zero_b, out_multi_b, err_cnt_b} !== {1'b1, e.cl, e.z, e.m, 2'(m_err_b)}) begin
        errors++;
        $display("FAIL errword_b[%02h]: got c=%0d z=%b m=%b e=%0d want c=%0d z=%b m=%b e=%0d",
                 words[k], out_code_b, out_zero_b, out_multi_b, err_cnt_b, e.cl, e.z, e.m, m_err_b);
      end
    end
    cyc(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_stall();
    exp_t e;
    exp_t f;
    cyc(0, 1, 8'h02, 1, 0);
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 8'h40, 0, 0);
      checks++;
      if ({in_ready_a, out_valid_a, out_code_a, in_ready_b, out_valid_b, out_code_b} !== {1'b0, 1'b1, e.cm, 1'b0, 1'b1, e.cl} || sb.size() != 0) begin
        errors++;
        $display("FAIL stall[%0d]: got ra=%b va=%b ca=%0d rb=%b vb=%b cb=%0d want ready 0, valid 1, code 1",
                 k, in_ready_a, out_valid_a, out_code_a, in_ready_b, out_valid_b, out_code_b);
      end
    end
    cyc(0, 1, 8'h40, 1, 0);
    f = sb.pop_front();
    checks++;
    if ({out_valid_a, out_code_a, out_valid_b, out_code_b} !== {1'b1, f.cm, 1'b1, f.cl}) begin
      errors++;
      $display("FAIL release: got va=%b ca=%0d vb=%b cb=%0d want 1 %0d 1 %0d",
               out_valid_a, out_code_a, out_valid_b, out_code_b, f.cm, f.cl);
    end
    cyc(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [7:0] words [5];
    words[0] = 8'h03; words[1] = 8'hff; words[2] = 8'h81; words[3] = 8'h18; words[4] = 8'hc0;
    cyc(0, 0, 8'h00, 1, 1);
    checks++;
    if (err_cnt_a !== 8'd0 || err_cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL clear_alone: got a=%0d b=%0d want 0 0", err_cnt_a, err_cnt_b);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, words[k], 1, 0);
      e = sb.pop_front();
      checks++;
      if ({out_code_a, out_multi_a, err_cnt_a, out_code_b, out_multi_b, err_cnt_b} !== {e.cm, e.m, 8'(m_err_a), e.cl, e.m, 2'(m_err_b)}) begin
        errors++;
        $display("FAIL sat[%0d]: got ca=%0d ma=%b ea=%0d cb=%0d mb=%b eb=%0d want %0d %b %0d %0d %b %0d",
                 k, out_code_a, out_multi_a, err_cnt_a, out_code_b, out_multi_b, err_cnt_b,
                 e.cm, e.m, m_err_a, e.cl, e.m, m_err_b);
      end
    end
    checks++;
    if (err_cnt_b !== 2'd3 || err_cnt_a !== 8'd5) begin
      errors++;
      $display("FAIL saturated: got a=%0d b=%0d want 5 3", err_cnt_a, err_cnt_b);
    end
    cyc(0, 1, 8'h00, 1, 1);
    e = sb.pop_front();
    checks++;
    if (err_cnt_a !== 8'd1 || err_cnt_b !== 2'd1 || out_zero_a !== e.z) begin
      errors++;
      $display("FAIL clear_with_err: got a=%0d b=%0d z=%b want 1 1 1", err_cnt_a, err_cnt_b, out_zero_a);
    end
    cyc(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_reset_stalled();
    cyc(0, 1, 8'h0c, 1, 0);
    void'(sb.pop_front());
    cyc(0, 1, 8'h01, 0, 0);
    checks++;
    if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || err_cnt_a !== 8'(m_err_a)) begin
      errors++;
      $display("FAIL pre_reset: got v=%b r=%b e=%0d want 1 0 %0d", out_valid_a, in_ready_a, err_cnt_a, m_err_a);
    end
    cyc(1, 1, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    checks++;
    if ({out_valid_a, err_cnt_a, in_ready_a, out_valid_b, err_cnt_b, in_ready_b} !== {1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_stalled: got va=%b ea=%0d ra=%b vb=%b eb=%0d rb=%b want 0 0 1 0 0 1",
               out_valid_a, err_cnt_a, in_ready_a, out_valid_b, err_cnt_b, in_ready_b);
    end
  endtask

  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_stall();
    test_saturation();
    test_reset_stalled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
